spi_frame_master: RTL and testbench

// - SPI mode-0 master for the fixed-length LSB-first frame protocol of the Raspberry-Pi

---
 rtl/spi_frame_master.sv | 94 +++++++++
 tb/tb_spi_frame_master.sv | 139 +++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 master shifting a fixed-length LSB-first frame out on MOSI while capturing MISO.
// Define SPI_FRAME_MASTER_MISO_SYNC_EN to pass SPI_MISO through a 2-FF synchroniser before sampling.
module spi_frame_master #(
  parameter int FRAME_BITS = 1024,
  parameter int CLK_DIV    = 16,
  parameter int CS_SETUP   = 16,
  parameter int CS_HOLD    = 16,
  parameter int CS_GAP     = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [FRAME_BITS-1:0] TX_DATA,
  input  logic                  SPI_MISO,
  output logic                  SPI_CS,
  output logic                  SPI_CLK,
  output logic                  SPI_MOSI,
  output logic [FRAME_BITS-1:0] RX_DATA,
  output logic                  BUSY,
  output logic                  DONE
);
  localparam int M1   = CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD;
  localparam int M2   = CS_GAP > 2 * CLK_DIV ? CS_GAP : 2 * CLK_DIV;
  localparam int MAXC = M1 > M2 ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = $clog2(FRAME_BITS + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr;
  logic sclk_q, mosi_q, miso_s, half_end, bit_end, last_bit;
`ifdef SPI_FRAME_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync;
  always_ff @(posedge CLK)
    miso_sync <= RESET ? 2'b00 : {miso_sync[0], SPI_MISO};
  assign miso_s = miso_sync[1];
`else
  assign miso_s = SPI_MISO;
`endif
  // Each bit is one SCLK period: low for CLK_DIV cycles, then high; MISO is taken on the high-phase's last cycle.
  assign half_end = cnt == CW'(CLK_DIV - 1);
  assign bit_end  = cnt == CW'(2 * CLK_DIV - 1);
  assign last_bit = bit_cnt == BW'(FRAME_BITS - 1);
  always_ff @(posedge CLK)
    state <= RESET ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = START ? SETUP : IDLE;
      SETUP:   state_nx = cnt == CW'(CS_SETUP - 1) ? SHIFT : SETUP;
      SHIFT:   state_nx = bit_end && last_bit ? HOLD : SHIFT;
      HOLD:    state_nx = cnt == CW'(CS_HOLD - 1) ? GAP : HOLD;
      GAP:     state_nx = cnt == CW'(CS_GAP - 1) ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      RX_DATA <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      cnt <= (state == IDLE || state_nx != state || (state == SHIFT && bit_end)) ? '0 : cnt + 1'b1;
      if (state == IDLE && START) begin
        tx_sr   <= TX_DATA;
        mosi_q  <= TX_DATA[0];
        bit_cnt <= '0;
      end
      if (state == SHIFT && half_end)
        sclk_q <= 1'b1;
      if (state == SHIFT && bit_end) begin
        sclk_q  <= 1'b0;
        rx_sr   <= {miso_s, rx_sr[FRAME_BITS-1:1]};
        tx_sr   <= tx_sr >> 1;
        mosi_q  <= last_bit ? 1'b0 : tx_sr[1];
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == HOLD && state_nx == GAP)
        RX_DATA <= rx_sr;
    end
  end
  always_comb begin
    SPI_CS   = !(state == SETUP || state == SHIFT || state == HOLD);
    SPI_CLK  = sclk_q;
    SPI_MOSI = mosi_q;
    BUSY     = state != IDLE;
    DONE     = state == GAP && cnt == '0;
  end
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: randomized frames against a protocol-level model of an SPI mode-0 slave.
module tb_spi_frame_master;
  localparam int FB = 16, D = 4, S = 16, H = 16, G = 32;
  localparam int LAT = 1 + S + 2 * D * FB + H;
  logic CLK = 1'b0, RESET = 1'b1, START = 1'b0, SPI_MISO;
  logic [FB-1:0] TX_DATA = '0, RX_DATA;
  logic SPI_CS, SPI_CLK, SPI_MOSI, BUSY, DONE;
  logic loopback = 1'b1, slave_bit = 1'b0;
  logic [FB-1:0] exp_rx = '0;
  int vectors = 0, miscompares = 0;
  assign SPI_MISO = loopback ? SPI_MOSI : slave_bit;
  always #5 CLK = ~CLK;
  spi_frame_master #(.FRAME_BITS(FB), .CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H), .CS_GAP(G)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .TX_DATA(TX_DATA), .SPI_MISO(SPI_MISO),
    .SPI_CS(SPI_CS), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .RX_DATA(RX_DATA),
    .BUSY(BUSY), .DONE(DONE));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic run_frame(input logic [FB-1:0] tx, input logic loop, input logic [FB-1:0] sw, input bit inject);
    int c, rises, falls, done_c, done_n, busy_c, mosi_hi, exp_hi;
    logic [FB-1:0] cap, exp;
    logic sclk_prev;
    bit rx_ok, cs_ok;
    loopback = loop;
    slave_bit = sw[0];
    exp = loop ? tx : sw;
    check("idle_cs", SPI_CS, 1);
    START = 1'b1;
    TX_DATA = tx;
    step();
    START = 1'b0;
    c = 1;
    check("start_cs_busy_mosi", {SPI_CS, BUSY, SPI_MOSI}, {1'b0, 1'b1, tx[0]});
    rises = 0; falls = 0; done_c = -1; done_n = 0; busy_c = -1; mosi_hi = 0;
    cap = '0; rx_ok = 1; cs_ok = 1; sclk_prev = 1'b0;
    while (busy_c < 0 && c < 400) begin
      mosi_hi += int'(SPI_MOSI);
      if (SPI_CLK && !sclk_prev) begin
        if (rises < FB) cap[rises] = SPI_MOSI;
        rises++;
      end
      if (!SPI_CLK && sclk_prev) begin
        falls++;
        slave_bit = falls < FB ? sw[falls] : 1'b0;
      end
      if (DONE) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end else if (done_c < 0 && RX_DATA !== exp_rx) rx_ok = 0;
      if (done_c >= 0 && SPI_CS !== 1'b1) cs_ok = 0;
      if (!BUSY) busy_c = c;
      else begin
        sclk_prev = SPI_CLK;
        START = inject && (c == 59 || (done_c >= 0 && c == done_c + 4));
        TX_DATA = ~tx;
        step();
        START = 1'b0;
        c++;
      end
    end
    exp_hi = int'(tx[0]) * (S + 2 * D) + $countones(tx >> 1) * 2 * D;
    check("done_cycle", done_c, LAT);
    check("done_count", done_n, 1);
    check("sclk_rises", rises, FB);
    check("mosi_bits", cap, tx);
    check("mosi_high_cycles", mosi_hi, exp_hi);
    check("rx_data", RX_DATA, exp);
    check("rx_stable_before_done", rx_ok, 1);
    check("cs_high_after_done", cs_ok, 1);
    check("busy_fall_cycle", busy_c, LAT + G);
    exp_rx = exp;
  endtask
  task automatic reset_mid_shift(input logic [FB-1:0] tx);
    int rises, done_n, cs_low;
    logic sclk_prev;
    loopback = 1'b1;
    START = 1'b1;
    TX_DATA = tx;
    step();
    START = 1'b0;
    rises = 0;
    sclk_prev = 1'b0;
    for (int i = 0; i < 400 && rises < 8; i++) begin
      if (SPI_CLK && !sclk_prev) rises++;
      sclk_prev = SPI_CLK;
      if (rises < 8) step();
    end
    check("reset_reached_bit7", rises, 8);
    RESET = 1'b1;
    step();
    check("reset_outputs", {SPI_CS, SPI_CLK, SPI_MOSI, BUSY, DONE}, 5'b10000);
    check("reset_rx", RX_DATA, 0);
    RESET = 1'b0;
    exp_rx = '0;
    done_n = 0;
    cs_low = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      done_n += int'(DONE);
      cs_low += int'(!SPI_CS);
    end
    check("reset_no_done", done_n, 0);
    check("reset_cs_stays_high", cs_low, 0);
  endtask
  initial begin
    logic [FB-1:0] t, w;
    repeat (3) step();
    check("rst_cs", SPI_CS, 1);
    check("rst_clk", SPI_CLK, 0);
    check("rst_mosi", SPI_MOSI, 0);
    check("rst_rx", RX_DATA, 0);
    check("rst_busy_done", {BUSY, DONE}, 2'b00);
    RESET = 1'b0;
    step();
    run_frame(16'h3C96, 1'b0, 16'h8001, 0);
    run_frame(16'hA5C3, 1'b1, '0, 0);
    run_frame(16'h0001, 1'b1, '0, 0);
    run_frame(16'h5A17, 1'b1, '0, 1);
    for (int k = 0; k < 6; k++) begin
      t = FB'($urandom);
      w = FB'($urandom);
      run_frame(t, 1'($urandom_range(0, 1)), w, bit'($urandom_range(0, 1)));
    end
    reset_mid_shift(16'hFFFF);
    t = FB'($urandom);
    run_frame(t, 1'b1, '0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
